// File: rtl/alu_seq_core_if.sv
// Handshake and result bus between an ALU requester and alu_seq_core.
// The master issues operations; the slave (the core) returns results and flags.
interface alu_seq_core_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             result_we;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             busy;

    modport master (
        output start_valid, op, a, b,
        input  start_ready, result, result_we, carry, zero, overflow, busy
    );

    modport slave (
        input  start_valid, op, a, b,
        output start_ready, result, result_we, carry, zero, overflow, busy
    );
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU execution stage: single-cycle ops go through EXEC, MUL runs an
// 8-step shift-add; results and flags are registered and strobed once via result_we.
module alu_seq_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_core_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]       state,     state_n;
    logic [2:0]       op_q,      op_n;
    logic [WIDTH-1:0] a_q,       a_n;
    logic [WIDTH-1:0] b_q,       b_n;
    logic [ACC_W-1:0] acc,       acc_n;
    logic [CNT_W-1:0] cnt,       cnt_n;
    logic [WIDTH-1:0] result_q,  result_n;
    logic             carry_q,   carry_n;
    logic             zero_q,    zero_n;
    logic             ovf_q,     ovf_n;
    logic             we_q,      we_n;

    logic             accept;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [ACC_W-1:0] mul_addend;
    logic [ACC_W-1:0] acc_sum;
    logic             mul_last;

    assign accept = bus.start_valid && bus.start_ready;

    // Extended add/sub so the top bit is the carry or borrow.
    assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ext = {1'b0, a_q} - {1'b0, b_q};

    // One shift-add step: add the multiplicand shifted by the current bit index.
    assign mul_addend = b_q[cnt[IDX_W-1:0]] ? (ACC_W'(a_q) << cnt) : '0;
    assign acc_sum    = acc + mul_addend;
    assign mul_last   = (cnt == CNT_W'(WIDTH - 1));

    // Single-cycle operations evaluated from the captured operands.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = result_q;
        carry_n  = carry_q;
        zero_n   = zero_q;
        ovf_n    = ovf_q;
        we_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_n    = bus.op;
                    a_n     = bus.a;
                    b_n     = bus.b;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_n = alu_res;
                carry_n  = alu_c;
                zero_n   = (alu_res == '0);
                ovf_n    = alu_v;
                we_n     = 1'b1;
                state_n  = S_DONE;
            end
            S_MUL: begin
                acc_n = acc_sum;
                if (mul_last) begin
                    result_n = acc_sum[WIDTH-1:0];
                    carry_n  = |acc_sum[ACC_W-1:WIDTH];
                    zero_n   = (acc_sum[WIDTH-1:0] == '0);
                    ovf_n    = 1'b0;
                    we_n     = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any op in flight and clears all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            a_q      <= a_n;
            b_q      <= b_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            result_q <= result_n;
            carry_q  <= carry_n;
            zero_q   <= zero_n;
            ovf_q    <= ovf_n;
            we_q     <= we_n;
        end
    end

    assign bus.start_ready = (state == S_IDLE) && !reset;
    assign bus.busy        = (state != S_IDLE);
    assign bus.result      = result_q;
    assign bus.result_we   = we_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
endmodule
